// File: rtl/vga_axil_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_axil_pkg
// Brief    : Shared AXI-Lite types, arbitration select and master FSM states.
// Revision : 1.0
// ============================================================================
package vga_axil_pkg;

  localparam int c_AXIL_ADDR_W = 32;
  localparam int c_AXIL_DATA_W = 32;
  localparam int c_AXIL_STRB_W = c_AXIL_DATA_W / 8;

  typedef logic [c_AXIL_ADDR_W-1:0] axil_addr_t;
  typedef logic [c_AXIL_DATA_W-1:0] axil_data_t;
  typedef logic [c_AXIL_STRB_W-1:0] axil_strb_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axil_resp_e;

  typedef enum logic {
    ARB_WR = 1'b0,
    ARB_RD = 1'b1
  } axil_arb_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4
  } axil_state_e;

  // Expands a byte strobe into a bit mask over the data word.
  function automatic axil_data_t strb_mask(input axil_strb_t strb);
    axil_data_t mask;
    for (int i = 0; i < c_AXIL_STRB_W; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axil_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_axil_if
// Brief    : AXI-Lite bundle (AW, W, B, AR, R) with master and slave views.
// Revision : 1.0
// ============================================================================
interface vga_axil_if;

  logic                     awvalid;
  logic                     awready;
  vga_axil_pkg::axil_addr_t awaddr;
  logic [2:0]               awprot;

  logic                     wvalid;
  logic                     wready;
  vga_axil_pkg::axil_data_t wdata;
  vga_axil_pkg::axil_strb_t wstrb;

  logic                     bvalid;
  logic                     bready;
  vga_axil_pkg::axil_resp_e bresp;

  logic                     arvalid;
  logic                     arready;
  vga_axil_pkg::axil_addr_t araddr;
  logic [2:0]               arprot;

  logic                     rvalid;
  logic                     rready;
  vga_axil_pkg::axil_data_t rdata;
  vga_axil_pkg::axil_resp_e rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface
`default_nettype wire

// File: rtl/vga_axil_master_fsm.sv
`default_nettype none
// ============================================================================
// Module   : vga_axil_master_fsm
// Brief    : Native write/read request port to AXI-Lite master, inline arbiter.
// Revision : 1.0
// ============================================================================
module vga_axil_master_fsm
  import vga_axil_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,

  input  logic       wr_valid_i,
  output logic       wr_ready_o,
  input  axil_addr_t wr_addr_i,
  input  axil_data_t wr_data_i,
  input  axil_strb_t wr_strb_i,

  input  logic       rd_valid_i,
  output logic       rd_ready_o,
  input  axil_addr_t rd_addr_i,

  output logic       wr_done_o,
  output axil_resp_e wr_resp_o,

  output logic       rd_done_o,
  output axil_data_t rd_data_o,
  output axil_resp_e rd_resp_o,

  vga_axil_if.master axil_if
);

  localparam logic [2:0] c_AXI_PROT = 3'b000;

  axil_state_e r_state;
  axil_state_e w_next_state;
  axil_arb_e   r_last_grant;

  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_arvalid;
  axil_addr_t  r_addr;
  axil_data_t  r_wdata;
  axil_strb_t  r_wstrb;

  logic        r_wr_done;
  logic        r_rd_done;
  axil_resp_e  r_wr_resp;
  axil_resp_e  r_rd_resp;
  axil_data_t  r_rd_data;

  logic        w_wr_wins_tie;
  logic        w_wr_accept;
  logic        w_rd_accept;
  logic        w_aw_done;
  logic        w_w_done;
  logic        w_bready;
  logic        w_rready;
  logic        w_b_hs;
  logic        w_r_hs;

  // A tie goes to write unless round-robin says write was granted last.
  assign w_wr_wins_tie = (RR_EN == 1'b0) || (r_last_grant == ARB_RD);

  assign w_wr_accept = wr_valid_i && wr_ready_o;
  assign w_rd_accept = rd_valid_i && rd_ready_o;

  // A channel counts as done once its valid has dropped or is handshaking now.
  assign w_aw_done = !r_awvalid || axil_if.awready;
  assign w_w_done  = !r_wvalid  || axil_if.wready;
  assign w_b_hs    = w_bready && axil_if.bvalid;
  assign w_r_hs    = w_rready && axil_if.rvalid;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_wr_accept) begin
          w_next_state = WR_AW_W;
        end else if (w_rd_accept) begin
          w_next_state = RD_AR;
        end
      end
      WR_AW_W: begin
        if (w_aw_done && w_w_done) begin
          w_next_state = WR_B;
        end
      end
      WR_B: begin
        if (axil_if.bvalid) begin
          w_next_state = IDLE;
        end
      end
      RD_AR: begin
        if (axil_if.arready) begin
          w_next_state = RD_R;
        end
      end
      RD_R: begin
        if (axil_if.rvalid) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    wr_ready_o = 1'b0;
    rd_ready_o = 1'b0;
    w_bready   = 1'b0;
    w_rready   = 1'b0;
    case (r_state)
      IDLE: begin
        wr_ready_o = !rd_valid_i || w_wr_wins_tie;
        rd_ready_o = !wr_valid_i || !w_wr_wins_tie;
      end
      WR_B:    w_bready = 1'b1;
      RD_R:    w_rready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last_grant <= ARB_RD;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_wr_done    <= 1'b0;
      r_rd_done    <= 1'b0;
      r_wr_resp    <= RESP_OKAY;
      r_rd_resp    <= RESP_OKAY;
      r_rd_data    <= '0;
    end else begin
      r_wr_done <= 1'b0;
      r_rd_done <= 1'b0;

      if (w_wr_accept) begin
        r_addr       <= wr_addr_i;
        r_wdata      <= wr_data_i;
        r_wstrb      <= wr_strb_i;
        r_awvalid    <= 1'b1;
        r_wvalid     <= 1'b1;
        r_last_grant <= ARB_WR;
      end else if (w_rd_accept) begin
        r_addr       <= rd_addr_i;
        r_arvalid    <= 1'b1;
        r_last_grant <= ARB_RD;
      end

      if (r_awvalid && axil_if.awready) begin
        r_awvalid <= 1'b0;
      end
      if (r_wvalid && axil_if.wready) begin
        r_wvalid <= 1'b0;
      end
      if (r_arvalid && axil_if.arready) begin
        r_arvalid <= 1'b0;
      end

      // Responses are passed through as-is; an error never triggers a retry.
      if (w_b_hs) begin
        r_wr_resp <= axil_if.bresp;
        r_wr_done <= 1'b1;
      end
      if (w_r_hs) begin
        r_rd_data <= axil_if.rdata;
        r_rd_resp <= axil_if.rresp;
        r_rd_done <= 1'b1;
      end
    end
  end

  assign axil_if.awvalid = r_awvalid;
  assign axil_if.awaddr  = r_addr;
  assign axil_if.awprot  = c_AXI_PROT;
  assign axil_if.wvalid  = r_wvalid;
  assign axil_if.wdata   = r_wdata;
  assign axil_if.wstrb   = r_wstrb;
  assign axil_if.bready  = w_bready;
  assign axil_if.arvalid = r_arvalid;
  assign axil_if.araddr  = r_addr;
  assign axil_if.arprot  = c_AXI_PROT;
  assign axil_if.rready  = w_rready;

  assign wr_done_o = r_wr_done;
  assign wr_resp_o = r_wr_resp;
  assign rd_done_o = r_rd_done;
  assign rd_data_o = r_rd_data;
  assign rd_resp_o = r_rd_resp;

endmodule
`default_nettype wire

// File: doc/vga_axil_master_fsm.md
VGA_AXIL_MASTER_FSM -- requirements
Module: vga_axil_master_fsm

Interface
REQ-001 SHALL have parameter RR_EN, default 1, 1 = round-robin arbitration on read/write ties, 0 = fixed write priority.
REQ-002 SHALL have clk_i  input  1  single clock; all logic rises on posedge clk_i.
REQ-003 SHALL have rst_i  input  1  synchronous, active-high reset.
REQ-004 SHALL have wr_valid_i  input  1  native write request.
REQ-005 SHALL have wr_ready_o  output  1  write request accepted when wr_valid_i & wr_ready_o.
REQ-006 SHALL have wr_addr_i, wr_data_i, wr_strb_i  input  axil_addr_t / axil_data_t / axil_strb_t  write payload.
REQ-007 SHALL have rd_valid_i  input  1; rd_ready_o  output  1; rd_addr_i  input  axil_addr_t  native read request.
REQ-008 SHALL have wr_done_o  output  1; wr_resp_o  output  axil_resp_e  write completion pulse and response.
REQ-009 SHALL have rd_done_o  output  1; rd_data_o  output  axil_data_t; rd_resp_o  output  axil_resp_e  read completion.
REQ-010 SHALL have axil_if  vga_axil_if master modport  --  AXI-Lite master port (AW, W, B, AR, R channels).

Function
REQ-011 FSM states SHALL be IDLE, WR_AW_W, WR_B, RD_AR, RD_R.
REQ-012 wr_ready_o and rd_ready_o SHALL be high only in IDLE; only one request SHALL be accepted per cycle.
REQ-013 In IDLE, a lone wr_valid_i SHALL go to WR_AW_W and a lone rd_valid_i SHALL go to RD_AR; on a tie, write SHALL win if RR_EN=0, else the direction not granted last SHALL win.
REQ-014 Only the winner's ready SHALL be high on a tie; the loser SHALL stay pending without loss.
REQ-015 Accepted address, data and strobe SHALL be registered; AXI payload SHALL stay stable while its valid is high.
REQ-016 AWVALID and WVALID SHALL both rise the cycle after acceptance; each SHALL drop independently after its own handshake.
REQ-017 WR_AW_W SHALL exit to WR_B only when both AW and W handshakes have completed, in either order or in the same cycle.
REQ-018 BREADY SHALL be high throughout WR_B; on the B handshake the FSM SHALL return to IDLE, and wr_done_o SHALL pulse 1 cycle later with wr_resp_o = BRESP.
REQ-019 ARVALID SHALL rise the cycle after read acceptance; after the AR handshake the FSM SHALL enter RD_R with RREADY high.
REQ-020 On the R handshake, RDATA/RRESP SHALL be registered into rd_data_o/rd_resp_o, rd_done_o SHALL pulse 1 cycle later, and the FSM SHALL return to IDLE.
REQ-021 rd_data_o and rd_resp_o SHALL hold until the next read completion; wr_resp_o SHALL hold until the next write completion.
REQ-022 AWPROT and ARPROT SHALL be 3'b000; valids SHALL never depend combinationally on ready.
REQ-023 Minimum turnaround SHALL be: accept N, AW/W handshake N+1, B N+2, done N+3, next accept N+3.
REQ-024 Non-OKAY responses SHALL be reported unchanged and SHALL NOT cause a retry.

Reset
REQ-025 rst_i high at a clock edge SHALL force IDLE and clear AWVALID, WVALID, BREADY, ARVALID, RREADY, wr_done_o and rd_done_o.
REQ-026 Reset SHALL clear rd_data_o to 0, set wr_resp_o and rd_resp_o to OKAY, and set the last-grant register to read.
REQ-027 Reset mid-transaction SHALL abandon the transaction with no done pulse; ready SHALL be high the first cycle after rst_i falls.

Structure
REQ-028 axil_strb_t, the arbitration-select enum and the FSM state enum SHALL be defined in vga_axil_pkg alongside axil_addr_t, axil_data_t and axil_resp_e.
REQ-029 The block SHALL be a single module with no sub-module; the arbiter SHALL be inline.

Verification
REQ-030 Loopback with vga_axil_slave_fsm: write 0xDEADBEEF to 0x10, then read 0x10 -> wr_resp OKAY, rd_data 0xDEADBEEF, rd_resp OKAY.
REQ-031 Slave holds AWREADY low 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 4 cycles with stable payload, single wr_done.
REQ-032 wr_valid and rd_valid held together with RR_EN=1 -> order W, R, W, R over 4 grants; with RR_EN=0 -> all writes first.
REQ-033 Slave returns BRESP=SLVERR, RRESP=DECERR -> wr_resp_o=SLVERR, rd_resp_o=DECERR, no retry issued.
REQ-034 rst_i pulsed during RD_R -> no rd_done, RREADY low next cycle, rd_ready high the cycle after rst_i falls.
REQ-035 100 back-to-back random writes then reads against the slave model -> every read matches the scoreboard, with 3-cycle turnaround when slave ready is always high.
